// File: rtl/regfile_2r1w.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_2r1w
//
// Integer register file x0..x31 feeding the main ALU. It has two
// combinational read ports and one synchronous write port. x0 has no
// storage and always reads zero. x2 (the stack pointer) resets to SP_INIT.
// Every other register resets to zero.
//
// Parameters:
//   XLEN    - data width of each register and of all data ports
//   NREG    - number of architectural registers (address width is fixed at
//             5 bits, so this must be 32)
//   SP_INIT - reset value of x2
//
// Ports:
//   clk     - clock, rising-edge active
//   rst_n   - asynchronous active-low reset (already synchronised upstream)
//   rs1     - read address, port 1 (ALU operand A)
//   rs2     - read address, port 2 (ALU operand B path)
//   rd      - write address
//   we      - write enable, sampled at rising clk
//   wdata   - write data
//   rdata1  - read data, port 1 (combinational)
//   rdata2  - read data, port 2 (combinational)
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, each read port forwards wdata in the
//   same cycle if it addresses the register being written. This is
//   write-through bypass. When the macro is undefined, reads return the
//   stored contents only, giving write-after-read ordering.
// ---------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int unsigned          XLEN    = 32,
    parameter int unsigned          NREG    = 32,
    parameter logic [XLEN-1:0]      SP_INIT = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [4:0]              rd,
    input  logic                    we,
    input  logic [XLEN-1:0]         wdata,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2
);

    // Physical storage for x1..x31 only; x0 is synthesised as a constant.
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];

    // Write decode uses only rd/we, so unknown read addresses can never
    // disturb stored state. A write to x0 matches no entry and is dropped.
    always_comb begin
        for (int unsigned i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (rd == 5'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= (i == 2) ? SP_INIT : '0;
            end
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst_n. A write held during reset will never
    // land, so forwarding it would show a value the array never holds.
    logic wr_live;
    assign wr_live = rst_n && we && (rd != 5'd0);
`endif

    always_comb begin
        rdata1 = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (rs1 == 5'(i)) begin
                rdata1 = regs_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (rd == rs1)) begin
            rdata1 = wdata;
        end
`endif
    end

    always_comb begin
        rdata2 = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (rs2 == 5'(i)) begin
                rdata2 = regs_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (rd == rs2)) begin
            rdata2 = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
`timescale 1ns/1ps
module tb_regfile_2r1w;

    localparam logic [31:0] SP = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural view: one word per register, index 0 unused.
    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile_2r1w #(
        .XLEN    (32),
        .NREG    (32),
        .SP_INIT (SP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .we     (we),
        .wdata  (wdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n && we && rd != 5'd0 && rd == a) return wdata;
`endif
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[2] = SP;
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_rd1"}, rdata1, exp_rd(rs1));
        check({tag, "_rd2"}, rdata2, exp_rd(rs2));
    endtask

    // Advance one rising edge, applying the architectural write rule.
    task automatic clock_edge();
        @(posedge clk);
        if (rst_n && we && rd != 5'd0) model[rd] = wdata;
        #1;
    endtask

    initial begin
        rst_n = 1'b1; we = 1'b0; rd = '0; rs1 = '0; rs2 = '0; wdata = '0;
        model_reset();

        // Asynchronous reset with no clock edge involved.
        #2;
        rst_n = 1'b0;
        rs1 = 5'd2; rs2 = 5'd31;
        #1;
        check("rst_x2", rdata1, SP);
        check("rst_x31", rdata2, 32'h0);
        rs1 = 5'd5;
        #1;
        check("rst_x5", rdata1, 32'h0);

        // Writes are ignored while reset is held across an edge.
        we = 1'b1; rd = 5'd3; wdata = 32'h1234_5678; rs1 = 5'd3;
        @(posedge clk); #1;
        check("rst_wr_ignored", rdata1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; we = 1'b0;
        #1;

        // Basic write, dual-port read, we low holds.
        we = 1'b1; rd = 5'd5; wdata = 32'hDEAD_BEEF;
        clock_edge();
        we = 1'b0; rs1 = 5'd5; rs2 = 5'd5;
        #1;
        check("x5_p1", rdata1, 32'hDEAD_BEEF);
        check("x5_p2", rdata2, 32'hDEAD_BEEF);
        wdata = 32'h1;
        clock_edge();
        check("x5_we0", rdata1, 32'hDEAD_BEEF);

        // Write to x0 is discarded.
        we = 1'b1; rd = 5'd0; wdata = 32'hFFFF_FFFF;
        clock_edge();
        we = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
        #1;
        check("x0_p1", rdata1, 32'h0);
        check("x0_p2", rdata2, 32'h0);
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check($sformatf("scan_x%0d", i), rdata1, model[i]);
        end

        // Same-cycle read/write of one register.
        we = 1'b1; rd = 5'd7; wdata = 32'h11;
        clock_edge();
        we = 1'b1; rd = 5'd7; wdata = 32'h22; rs1 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_pre", rdata1, 32'h22);
`else
        check("hazard_pre", rdata1, 32'h11);
`endif
        clock_edge();
        we = 1'b0;
        #1;
        check("hazard_post", rdata1, 32'h22);

        // Reset pulse mid-operation with a write held.
        we = 1'b1; rd = 5'd10; wdata = 32'hA5A5_A5A5;
        clock_edge();
        wdata = 32'h5; rs1 = 5'd10; rs2 = 5'd2;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_x10", rdata1, 32'h0);
        check("midrst_x2", rdata2, SP);
        #2;
        rst_n = 1'b1;
        clock_edge();
        we = 1'b0;
        #1;
        check("post_rst_x10", rdata1, 32'h5);

        // Full sweep.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; rd = 5'(i); wdata = 32'h100 + 32'(i);
            clock_edge();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(32 - i);
            #1;
            check($sformatf("sweep_a%0d", i), rdata1, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
            check($sformatf("sweep_b%0d", i), rdata2, (i == 0) ? 32'h0 : 32'h100 + 32'(32 - i));
        end

        // Randomised traffic against the model, with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            we    = ($urandom_range(0, 1) == 1);
            rd    = 5'($urandom_range(0, 31));
            rs1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            wdata = $urandom;
            #1;
            check_reads("rand");
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_reads("rand_rst");
                #1;
                rst_n = 1'b1;
            end
            clock_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
